// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier-side blocks: id width derivation and
// product width helper.
package mult_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NUM_REQ = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // A single requester still needs a one-bit id.
  function automatic int id_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from r_rr_ptr,
// pointer moves past the winner only when the grant is taken.
module rr_arbiter
  import mult_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDW     = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_enable,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDW-1:0]     o_gnt_idx
);

  logic [IDW-1:0]     r_rr_ptr;
  logic [IDW-1:0]     w_cur;
  logic [IDW-1:0]     w_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_found;

  // The cursor wraps explicitly so non-power-of-two counts never index past NUM_REQ-1.
  always_comb begin
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_cur   = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req[w_cur]) begin
        w_found      = 1'b1;
        w_idx        = w_cur;
        w_gnt[w_cur] = 1'b1;
      end
      w_cur = (w_cur == IDW'(NUM_REQ - 1)) ? '0 : w_cur + 1'b1;
    end
    if (!i_enable) begin
      w_gnt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (i_advance) begin
      r_rr_ptr <= (w_idx == IDW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  assign o_gnt     = w_gnt;
  assign o_gnt_idx = w_idx;

endmodule

// File: rtl/unsigned_multiplier.sv
// Combinational unsigned multiplier with a full-width product.
module unsigned_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]         i_a,
  input  logic [WIDTH-1:0]         i_b,
  output logic [prod_w(WIDTH)-1:0] o_p
);

  assign o_p = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one combinational multiplier among NUM_REQ requesters with
// round-robin arbitration and a single registered, id-tagged response slot.
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDW     = id_width(NUM_REQ),
  localparam int PROD_W  = prod_w(WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [PROD_W-1:0]          rsp_product
);

  // Handshake: a request transfers on an edge where req_valid[i] && req_ready[i];
  // a response transfers where rsp_valid && rsp_ready. req_ready may depend on
  // req_valid, never the reverse; the slot accepts a new result when empty or draining.
  logic                 r_rsp_valid;
  logic [IDW-1:0]       r_rsp_id;
  logic [PROD_W-1:0]    r_rsp_product;

  logic                 w_slot_free;
  logic                 w_enable;
  logic                 w_xfer;
  logic [NUM_REQ-1:0]   w_gnt;
  logic [IDW-1:0]       w_gnt_idx;
  logic [WIDTH-1:0]     w_a;
  logic [WIDTH-1:0]     w_b;
  logic [PROD_W-1:0]    w_prod;

  assign w_slot_free = !r_rsp_valid || rsp_ready;
  assign w_enable    = w_slot_free && !rst;
  assign w_xfer      = |(w_gnt & req_valid);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (req_valid),
    .i_enable  (w_enable),
    .i_advance (w_xfer),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  // One-hot AND-OR operand mux feeding the single multiplier.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_a = w_a | req_a[i*WIDTH +: WIDTH];
        w_b = w_b | req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  unsigned_multiplier #(
    .WIDTH (WIDTH)
  ) u_mul (
    .i_a (w_a),
    .i_b (w_b),
    .o_p (w_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_product <= '0;
    end else if (w_xfer) begin
      r_rsp_valid   <= 1'b1;
      r_rsp_id      <= w_gnt_idx;
      r_rsp_product <= w_prod;
    end else if (rsp_ready) begin
      r_rsp_valid   <= 1'b0;
    end
  end

  assign req_ready   = w_gnt;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_product = r_rsp_product;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: a 4-requester and a 3-requester instance.
module tb_mult_share_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // NUM_REQ = 4 instance
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_product;

  // NUM_REQ = 3 instance
  logic        rst3;
  logic [2:0]  req_valid3;
  logic [2:0]  req_ready3;
  logic [23:0] req_a3;
  logic [23:0] req_b3;
  logic        rsp_valid3;
  logic        rsp_ready3;
  logic [1:0]  rsp_id3;
  logic [15:0] rsp_product3;

  mult_share_arbiter #(.WIDTH(8), .NUM_REQ(4)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product)
  );

  mult_share_arbiter #(.WIDTH(8), .NUM_REQ(3)) u_dut3 (
    .clk         (clk),
    .rst         (rst3),
    .req_valid   (req_valid3),
    .req_ready   (req_ready3),
    .req_a       (req_a3),
    .req_b       (req_b3),
    .rsp_valid   (rsp_valid3),
    .rsp_ready   (rsp_ready3),
    .rsp_id      (rsp_id3),
    .rsp_product (rsp_product3)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [17:0] exp_q[$];   // {id, product}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic reset4;
    rst       = 1'b1;
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_rsp(input string tag);
    logic [17:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, "_id"}, {30'd0, rsp_id}, {30'd0, e[17:16]});
      check({tag, "_prod"}, {16'd0, rsp_product}, {16'd0, e[15:0]});
    end
  endtask

  int exp_p4 [4] = '{2, 12, 30, 56};
  int exp_g4 [4] = '{1, 8, 1, 8};
  int exp_i3 [4] = '{0, 1, 2, 0};
  int exp_p3 [4] = '{2, 12, 30, 2};

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    rst3 = 1'b1; req_valid3 = '0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b1;

    // Reset state, with requests pending: nothing is granted
    tick();
    req_valid = 4'hF;
    #1;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    check("rst_rsp_prod", {16'd0, rsp_product}, 32'd0);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check("rst_rr_ptr", {30'd0, u_dut4.u_arb.r_rr_ptr}, 32'd0);

    // 1: single requester 3*5
    tick();
    rst = 1'b0;
    req_valid = 4'b0001; req_a[7:0] = 8'd3; req_b[7:0] = 8'd5;
    #1 check("t1_req_ready", {28'd0, req_ready}, 32'd1);
    exp_q.push_back({2'd0, 16'd15});
    tick();
    req_valid = '0;
    check_rsp("t1");
    check("t1_rr_ptr", {30'd0, u_dut4.u_arb.r_rr_ptr}, 32'd1);
    tick();
    check("t1_drain_valid", {31'd0, rsp_valid}, 32'd0);
    check("t1_drain_hold", {16'd0, rsp_product}, 32'd15);

    // 2: all four valid, streaming one grant per cycle
    reset4();
    req_a = {8'd7, 8'd5, 8'd3, 8'd1};
    req_b = {8'd8, 8'd6, 8'd4, 8'd2};
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) check_rsp($sformatf("t2_%0d", k - 1));
      if (k < 4) begin
        #1 check($sformatf("t2_gnt%0d", k), {28'd0, req_ready}, 32'd1 << k);
        exp_q.push_back({2'(k), 16'(exp_p4[k])});
        tick();
      end
    end
    req_valid = '0;
    check("t2_rr_wrap", {30'd0, u_dut4.u_arb.r_rr_ptr}, 32'd0);
    tick();

    // 3: backpressure with 255*255 held, then drain + reload
    reset4();
    req_a[15:8] = 8'd255; req_b[15:8] = 8'd255;
    req_a[23:16] = 8'd10; req_b[23:16] = 8'd20;
    req_valid = 4'b0010;
    #1 check("t3_gnt1", {28'd0, req_ready}, 32'd2);
    tick();
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t3_hold_valid%0d", k), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("t3_hold_id%0d", k), {30'd0, rsp_id}, 32'd1);
      check($sformatf("t3_hold_prod%0d", k), {16'd0, rsp_product}, 32'd65025);
      check($sformatf("t3_bp_ready%0d", k), {28'd0, req_ready}, 32'd0);
      check($sformatf("t3_bp_ptr%0d", k), {30'd0, u_dut4.u_arb.r_rr_ptr}, 32'd2);
      tick();
    end
    rsp_ready = 1'b1;
    #1 check("t3_reload_gnt", {28'd0, req_ready}, 32'd4);
    exp_q.push_back({2'd2, 16'd200});
    tick();
    req_valid = '0;
    check_rsp("t3_reload");
    tick();

    // 4: fairness between req0 and req3
    reset4();
    req_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("t4_gnt%0d", k), {28'd0, req_ready}, 32'(exp_g4[k]));
      tick();
    end

    // 5: asynchronous reset while a response is pending
    check("t5_pre_valid", {31'd0, rsp_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_valid", {31'd0, rsp_valid}, 32'd0);
    check("t5_async_prod", {16'd0, rsp_product}, 32'd0);
    check("t5_async_ready", {28'd0, req_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("t5_first_gnt", {28'd0, req_ready}, 32'd1);
    check("t5_rr_ptr", {30'd0, u_dut4.u_arb.r_rr_ptr}, 32'd0);
    tick();
    req_valid = '0;
    tick();

    // 6a: edge operands on requester 0
    req_a[7:0] = 8'd0; req_b[7:0] = 8'd200;
    req_valid = 4'b0001;
    tick();
    check("t6_zero", {16'd0, rsp_product}, 32'd0);
    req_a[7:0] = 8'd128; req_b[7:0] = 8'd2;
    tick();
    req_valid = '0;
    check("t6_128x2", {16'd0, rsp_product}, 32'd256);
    check("t6_id", {30'd0, rsp_id}, 32'd0);

    // 6b: NUM_REQ = 3, ids cycle 0,1,2,0
    rst3 = 1'b0;
    req_a3 = {8'd5, 8'd3, 8'd1};
    req_b3 = {8'd6, 8'd4, 8'd2};
    req_valid3 = 3'b111;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        check($sformatf("t6n3_valid%0d", k - 1), {31'd0, rsp_valid3}, 32'd1);
        check($sformatf("t6n3_id%0d", k - 1), {30'd0, rsp_id3}, 32'(exp_i3[k-1]));
        check($sformatf("t6n3_prod%0d", k - 1), {16'd0, rsp_product3}, 32'(exp_p3[k-1]));
        check($sformatf("t6n3_idlt3_%0d", k - 1), {31'd0, rsp_id3 < 2'd3}, 32'd1);
      end
      if (k < 4) begin
        #1 check($sformatf("t6n3_gnt%0d", k), {29'd0, req_ready3}, 32'd1 << exp_i3[k]);
        tick();
      end
    end
    req_valid3 = '0;
    check("t6n3_ptr", {30'd0, u_dut3.u_arb.r_rr_ptr}, 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
